demo_sequencer: RTL and testbench

Frame-rate timeline scheduler for the video effects path. It counts frames, steps through a fixed number of scenes, and generates a fade level for each scene's fade-in and fade-out. Between scenes it runs a request/acknowledge reconfiguration handshake with the configuration logic. It sits beside the video controller, is driven by the raster's `frame_end` strobe, and feeds scene select, fade level and frame count to the effect mixers.

---
 rtl/demo_sequencer.sv | 159 +++++++++++++++
 tb/tb_demo_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/demo_sequencer.sv
// Frame-rate timeline scheduler: steps through scenes with fade-in, run and
// fade-out phases, and a request/acknowledge reconfiguration between scenes.
module demo_sequencer #(
  parameter int SCENES       = 4,
  parameter int SCENE_FRAMES = 1024,
  parameter int FADE_FRAMES  = 32,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_end,
  input  logic        halt,
  input  logic        reconf_ack,
  output logic [1:0]  scene,
  output logic [7:0]  fade,
  output logic [11:0] frames,
  output logic        reconf_req,
  output logic        ack_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    RUN      = 3'd2,
    FADE_OUT = 3'd3,
    RECONF   = 3'd4
  } state_t;

  localparam logic [8:0]  STEP       = 9'(256 / FADE_FRAMES);
  localparam logic [12:0] FADE_LAST  = 13'(FADE_FRAMES);
  localparam logic [12:0] SCENE_LAST = 13'(SCENE_FRAMES);
  localparam logic [12:0] ACK_LAST   = 13'(ACK_TIMEOUT);
  localparam logic [1:0]  SCENE_MAX  = 2'(SCENES - 1);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [1:0]  scene_q, scene_d;
  logic [7:0]  fade_q, fade_d;
  logic [11:0] frames_q, frames_d;
  logic        req_q, req_d;
  logic        err_q, err_d;

  logic        tick;
  logic [12:0] cnt_inc;
  logic [8:0]  fade_up;
  logic [8:0]  fade_dn;
  logic        fade_done;
  logic        run_done;
  logic        ack_timeout;
  logic        reconf_exit;

  // halt freezes the frame timeline but never the acknowledge path
  assign tick        = frame_end & ~halt;
  assign cnt_inc     = cnt_q + 13'd1;
  assign fade_up     = {1'b0, fade_q} + STEP;
  assign fade_dn     = {1'b0, fade_q} - STEP;
  assign fade_done   = tick && (cnt_inc == FADE_LAST);
  assign run_done    = tick && (cnt_inc == SCENE_LAST);
  assign ack_timeout = tick && (cnt_inc == ACK_LAST);
  assign reconf_exit = reconf_ack || ack_timeout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset is asynchronous and needs no clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      scene_q  <= '0;
      fade_q   <= '0;
      frames_q <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scene_q  <= scene_d;
      fade_q   <= fade_d;
      frames_q <= frames_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (tick)        state_d = FADE_IN;
      FADE_IN:  if (fade_done)   state_d = RUN;
      RUN:      if (run_done)    state_d = FADE_OUT;
      FADE_OUT: if (fade_done)   state_d = RECONF;
      RECONF:   if (reconf_exit) state_d = FADE_IN;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    scene_d  = scene_q;
    fade_d   = fade_q;
    frames_d = tick ? frames_q + 12'd1 : frames_q;
    req_d    = req_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          fade_d = '0;
          cnt_d  = '0;
        end
      end
      FADE_IN: begin
        if (fade_done) begin
          fade_d = 8'hFF;
          cnt_d  = '0;
        end else if (tick) begin
          fade_d = fade_up[8] ? 8'hFF : fade_up[7:0];
          cnt_d  = cnt_inc;
        end
      end
      RUN: begin
        fade_d = 8'hFF;
        if (run_done) cnt_d = '0;
        else if (tick) cnt_d = cnt_inc;
      end
      FADE_OUT: begin
        if (fade_done) begin
          fade_d = '0;
          cnt_d  = '0;
          req_d  = 1'b1;
        end else if (tick) begin
          fade_d = fade_dn[8] ? 8'h00 : fade_dn[7:0];
          cnt_d  = cnt_inc;
        end
      end
      RECONF: begin
        if (reconf_exit) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          scene_d = (scene_q == SCENE_MAX) ? 2'd0 : scene_q + 2'd1;
          // an ack in the timeout cycle takes precedence and leaves no error
          if (!reconf_ack) err_d = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign scene      = scene_q;
  assign fade       = fade_q;
  assign frames     = frames_q;
  assign reconf_req = req_q;
  assign ack_err    = err_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Scoreboard bench for demo_sequencer: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_demo_sequencer;

  typedef struct {
    logic [1:0]  scene;
    logic [7:0]  fade;
    logic [11:0] frames;
    logic        req;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_end = 1'b0;
  logic        halt = 1'b0;
  logic        reconf_ack = 1'b0;
  logic [1:0]  scene;
  logic [7:0]  fade;
  logic [11:0] frames;
  logic        reconf_req;
  logic        ack_err;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   fr_m       = 0;

  logic [7:0] fin  [4] = '{8'd64, 8'd128, 8'd192, 8'd255};
  logic [7:0] fout [4] = '{8'd191, 8'd127, 8'd63, 8'd0};

  demo_sequencer #(
    .SCENES(3), .SCENE_FRAMES(4), .FADE_FRAMES(4), .ACK_TIMEOUT(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_end(frame_end), .halt(halt),
    .reconf_ack(reconf_ack), .scene(scene), .fade(fade), .frames(frames),
    .reconf_req(reconf_req), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      compared++;
      if (scene !== e.scene || fade !== e.fade || frames !== e.frames ||
          reconf_req !== e.req || ack_err !== e.err) begin
        mismatched++;
        $display("FAIL %s: got scene=%0d fade=%0d frames=%0d req=%b err=%b, expected scene=%0d fade=%0d frames=%0d req=%b err=%b",
                 e.name, scene, fade, frames, reconf_req, ack_err,
                 e.scene, e.fade, e.frames, e.req, e.err);
      end
    end
  end

  task automatic push(input logic [1:0] sc, input logic [7:0] fd,
                      input logic [11:0] fr, input logic rq, input logic er,
                      input string nm);
    exp_t e;
    e.scene = sc; e.fade = fd; e.frames = fr; e.req = rq; e.err = er; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic fe, input logic h, input logic ack,
                       input logic [1:0] sc, input logic [7:0] fd,
                       input logic [11:0] fr, input logic rq, input logic er,
                       input string nm);
    @(negedge clk);
    frame_end  = fe;
    halt       = h;
    reconf_ack = ack;
    @(posedge clk);
    #1;
    frame_end  = 1'b0;
    halt       = 1'b0;
    reconf_ack = 1'b0;
    push(sc, fd, fr, rq, er, nm);
  endtask

  // Scene entered in FADE_IN with fade 0: 4 fade-in, 4 run, 4 fade-out ticks.
  task automatic run_scene(input logic [1:0] sc, input logic er);
    for (int i = 0; i < 4; i++) begin
      fr_m++;
      check(1, 0, 0, sc, fin[i], 12'(fr_m), 0, er, "fade_in");
    end
    for (int i = 0; i < 4; i++) begin
      fr_m++;
      check(1, 0, 0, sc, 8'd255, 12'(fr_m), 0, er, "run");
    end
    for (int i = 0; i < 4; i++) begin
      fr_m++;
      check(1, 0, 0, sc, fout[i], 12'(fr_m), (i == 3), er, "fade_out");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check(0, 0, 0, 0, 0, 0, 0, 0, "reset_values");
    check(0, 0, 1, 0, 0, 0, 0, 0, "idle_ack_ignored");

    fr_m = 1;
    check(1, 0, 0, 0, 0, 12'(fr_m), 0, 0, "idle_to_fade_in");
    for (int i = 0; i < 4; i++) begin
      fr_m++;
      check(1, 0, 0, 0, fin[i], 12'(fr_m), 0, 0, "first_fade_in");
    end
    for (int i = 0; i < 3; i++) begin
      fr_m++;
      check(1, 0, 0, 0, 8'd255, 12'(fr_m), 0, 0, "first_run");
    end
    for (int i = 0; i < 6; i++)
      check(1, 1, 0, 0, 8'd255, 12'(fr_m), 0, 0, "halt_frozen");
    check(1, 1, 1, 0, 8'd255, 12'(fr_m), 0, 0, "halt_run_ack_ignored");
    fr_m++;
    check(1, 0, 0, 0, 8'd255, 12'(fr_m), 0, 0, "run_last_after_halt");
    for (int i = 0; i < 4; i++) begin
      fr_m++;
      check(1, 0, 0, 0, fout[i], 12'(fr_m), (i == 3), 0, "first_fade_out");
    end
    check(0, 0, 0, 0, 0, 12'(fr_m), 1, 0, "reconf_req_held");
    check(0, 0, 1, 1, 0, 12'(fr_m), 0, 0, "ack_scene_1");

    run_scene(1, 0);
    check(1, 1, 1, 2, 0, 12'(fr_m), 0, 0, "halt_ack_scene_2");

    run_scene(2, 0);
    for (int i = 0; i < 2; i++) begin
      fr_m++;
      check(1, 0, 0, 2, 0, 12'(fr_m), 1, 0, "reconf_wait");
    end
    fr_m++;
    check(1, 0, 1, 0, 0, 12'(fr_m), 0, 0, "ack_beats_timeout_wrap");

    run_scene(0, 0);
    for (int i = 0; i < 2; i++) begin
      fr_m++;
      check(1, 0, 0, 0, 0, 12'(fr_m), 1, 0, "timeout_wait");
    end
    fr_m++;
    check(1, 0, 0, 1, 0, 12'(fr_m), 0, 1, "timeout_exit");

    run_scene(1, 1);
    check(0, 0, 1, 2, 0, 12'(fr_m), 0, 1, "ack_keeps_err");

    run_scene(2, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    push(0, 0, 0, 0, 0, "async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check(1, 0, 0, 0, 0, 1, 0, 0, "post_reset_fade_in");
    check(1, 0, 0, 0, 8'd64, 2, 0, 0, "post_reset_step");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
